uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver, successor to the fixed 8N1 receiver. Supports configurable data

---
 rtl/uart_rx_cfg.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional parity, 1-2 stops.
// 3-tap majority sampling, valid/ready holding register with error flags.
module uart_rx_cfg #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CLKS = CLK_HZ / BAUD;
    localparam int MID  = CLKS / 2;
    localparam int CW   = $clog2(CLKS);

    localparam logic [CW-1:0] C_LAST = CW'(CLKS - 1);
    localparam logic [CW-1:0] C_SMP0 = CW'(MID - 1);
    localparam logic [CW-1:0] C_SMP1 = CW'(MID);
    localparam logic [CW-1:0] C_DEC  = CW'(MID + 1);
    localparam logic [3:0]    I_DLST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    I_SLST = 4'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_DLVR  = 3'd5;
    localparam logic [2:0] S_BRK   = 3'd6;

    logic                 s1_q, s2_q;
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           smp_q, smp_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 fe_acc_q, fe_acc_d;
    logic                 pe_acc_q, pe_acc_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d;
    logic                 pe_q, pe_d;
    logic                 ovr_q, ovr_d;
    logic                 rxs, maj, dec;

    assign rxs = s2_q;
    assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
    assign dec = (cnt_q == C_DEC);

    // Two-flop synchroniser for the asynchronous pin; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= rx;
            s2_q <= s1_q;
        end
    end

    // Frame FSM, bit timing, shift register and output holding register.
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
        smp_d    = smp_q;
        idx_d    = idx_q;
        sh_d     = sh_q;
        fe_acc_d = fe_acc_q;
        pe_acc_d = pe_acc_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        fe_d     = fe_q;
        pe_d     = pe_q;
        ovr_d    = 1'b0;
        if (cnt_q == C_SMP0) smp_d[0] = rxs;
        if (cnt_q == C_SMP1) smp_d[1] = rxs;
        if (valid_q && data_ready) valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d  = S_START;
                    idx_d    = '0;
                    fe_acc_d = 1'b0;
                    pe_acc_d = 1'b0;
                end
            end
            S_START: begin
                if (dec) state_d = maj ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (dec) begin
                    sh_d  = {maj, sh_q[DATA_BITS-1:1]};
                    idx_d = idx_q + 4'd1;
                    if (idx_q == I_DLST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end
                end
            end
            S_PAR: begin
                if (dec) begin
                    pe_acc_d = ((^sh_q) ^ maj) != (PARITY == 1);
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (dec) begin
                    if (!maj) fe_acc_d = 1'b1;
                    if (idx_q == I_SLST) state_d = S_DLVR;
                    else                 idx_d   = idx_q + 4'd1;
                end
            end
            S_DLVR: begin
                if (!valid_q || data_ready) begin
                    dout_d  = sh_q;
                    fe_d    = fe_acc_q;
                    pe_d    = pe_acc_q;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
                state_d = rxs ? S_IDLE : S_BRK;
            end
            S_BRK: begin
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            smp_q    <= '0;
            idx_q    <= '0;
            sh_q     <= '0;
            fe_acc_q <= 1'b0;
            pe_acc_q <= 1'b0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            fe_q     <= 1'b0;
            pe_q     <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            smp_q    <= smp_d;
            idx_q    <= idx_d;
            sh_q     <= sh_d;
            fe_acc_q <= fe_acc_d;
            pe_acc_q <= pe_acc_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            fe_q     <= fe_d;
            pe_q     <= pe_d;
            ovr_q    <= ovr_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign frame_err  = fe_q;
    assign parity_err = pe_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 8E1, 7O2) with a
// frame-level reference model feeding per-instance scoreboards.
module tb_uart_rx_cfg;
    localparam int CLKS = 16;

    typedef logic [10:0] exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       rx0, rx1, rx2;
    logic       rdy0, rdy1, rdy2;
    logic [7:0] do0, do1;
    logic [6:0] do2;
    logic       v0, v1, v2, fe0, fe1, fe2, pe0, pe1, pe2;
    logic       ov0, ov1, ov2, bz0, bz1, bz2;

    uart_rx_cfg #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .rx(rx0), .data_out(do0), .data_valid(v0),
        .data_ready(rdy0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(bz0));
    uart_rx_cfg #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .rx(rx1), .data_out(do1), .data_valid(v1),
        .data_ready(rdy1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(bz1));
    uart_rx_cfg #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .rx(rx2), .data_out(do2), .data_valid(v2),
        .data_ready(rdy2), .frame_err(fe2), .parity_err(pe2), .overrun(ov2), .busy(bz2));

    int   n_chk = 0;
    int   n_fail = 0;
    int   nov0 = 0, nov1 = 0, nov2 = 0;
    exp_t q0[$], q1[$], q2[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: word delivered, none expected", nm);
    endtask

    // Monitors: pop expected word on each accepted transfer, count overruns.
    always @(negedge clk) begin
        exp_t e;
        if (ov0 === 1'b1) nov0++;
        if (v0 && rdy0) begin
            if (q0.size() == 0) unexpected("u0");
            else begin
                e = q0.pop_front();
                chk("u0 word", {21'b0, fe0, pe0, 1'b0, do0}, {21'b0, e});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ov1 === 1'b1) nov1++;
        if (v1 && rdy1) begin
            if (q1.size() == 0) unexpected("u1");
            else begin
                e = q1.pop_front();
                chk("u1 word", {21'b0, fe1, pe1, 1'b0, do1}, {21'b0, e});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ov2 === 1'b1) nov2++;
        if (v2 && rdy2) begin
            if (q2.size() == 0) unexpected("u2");
            else begin
                e = q2.pop_front();
                chk("u2 word", {21'b0, fe2, pe2, 2'b0, do2}, {21'b0, e});
            end
        end
    end

    task automatic setrx(input int u, input logic v);
        case (u)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // Builds a frame from the line format, predicts the delivered word,
    // and drives it. gpos/gclk inverts one clock of one bit; rpos pulses
    // reset for 3 clocks inside that bit.
    task automatic send(input int u, input logic [8:0] d, input bit pflip,
                        input logic [1:0] sbad, input int gpos, input int gclk,
                        input int rpos, input bit push);
        int         db, par, sb, ones;
        bit         bits[$];
        logic [8:0] dm;
        bit         pb, fe, pe, s;
        db   = (u == 2) ? 7 : 8;
        par  = (u == 0) ? 0 : ((u == 1) ? 2 : 1);
        sb   = (u == 2) ? 2 : 1;
        dm   = d & ((9'd1 << db) - 9'd1);
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < db; i++) begin
            bits.push_back(dm[i]);
            if (dm[i]) ones++;
        end
        pe = 1'b0;
        if (par != 0) begin
            pb = (par == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
            pb = pb ^ pflip;
            bits.push_back(pb);
            if (par == 1) pe = ((ones + int'(pb)) % 2) != 1;
            else          pe = ((ones + int'(pb)) % 2) != 0;
        end
        fe = 1'b0;
        for (int k = 0; k < sb; k++) begin
            s = !sbad[k];
            bits.push_back(s);
            if (!s) fe = 1'b1;
        end
        if (push) begin
            case (u)
                0:       q0.push_back({fe, pe, dm});
                1:       q1.push_back({fe, pe, dm});
                default: q2.push_back({fe, pe, dm});
            endcase
        end
        for (int i = 0; i < bits.size(); i++) begin
            for (int c = 0; c < CLKS; c++) begin
                if (rpos == i && c == 5)
                    chk("outputs in reset", {23'b0, do0, v0, fe0, pe0, ov0, bz0}, 32'd0);
                setrx(u, bits[i] ^ (i == gpos && c == gclk));
                if (rpos == i) rst = (c >= 4 && c <= 6);
                @(negedge clk);
            end
        end
        setrx(u, 1'b1);
        if (rpos >= 0) rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        rx0  = 1'b1;
        rx1  = 1'b1;
        rx2  = 1'b1;
        rdy0 = 1'b1;
        rdy1 = 1'b1;
        rdy2 = 1'b1;
        idle(3);
        chk("reset state", {23'b0, do0, v0, fe0, pe0, ov0, bz0}, 32'd0);
        rst = 1'b0;
        idle(5);

        // 8N1 basic word
        send(0, 9'h0A5, 1'b0, 2'b00, -1, 0, -1, 1'b1);
        idle(20);

        // even parity: wrong then correct parity bit
        send(1, 9'h003, 1'b1, 2'b00, -1, 0, -1, 1'b1);
        idle(20);
        send(1, 9'h003, 1'b0, 2'b00, -1, 0, -1, 1'b1);
        idle(20);

        // 7O2 with second stop low, then line held low
        send(2, 9'h055, 1'b0, 2'b10, -1, 0, -1, 1'b1);
        rx2 = 1'b0;
        idle(40);
        chk("u2 busy while held low", {31'b0, bz2}, 32'd1);
        rx2 = 1'b1;
        idle(40);
        chk("u2 idle after release", {31'b0, bz2}, 32'd0);

        // short low glitch is a false start
        rx0 = 1'b0;
        idle(3);
        chk("glitch busy", {31'b0, bz0}, 32'd1);
        idle(1);
        rx0 = 1'b1;
        idle(16);
        chk("glitch back idle", {31'b0, bz0}, 32'd0);
        // single-clock spike in data bit 3 of 0x00
        send(0, 9'h000, 1'b0, 2'b00, 4, 9, -1, 1'b1);
        idle(20);

        // overrun: two back-to-back words while not ready
        @(posedge clk);
        #1 rdy0 = 1'b0;
        @(negedge clk);
        send(0, 9'h011, 1'b0, 2'b00, -1, 0, -1, 1'b1);
        send(0, 9'h022, 1'b0, 2'b00, -1, 0, -1, 1'b0);
        idle(20);
        chk("held word", {23'b0, v0, do0}, {23'b0, 1'b1, 8'h11});
        chk("overrun pulses", nov0, 32'd1);
        @(posedge clk);
        #1 rdy0 = 1'b1;
        idle(3);
        chk("after accept", {23'b0, v0, do0}, {23'b0, 1'b0, 8'h11});

        // reset mid-frame, then a clean frame
        send(0, 9'h07E, 1'b0, 2'b00, -1, 0, 8, 1'b0);
        idle(30);
        send(0, 9'h03C, 1'b0, 2'b00, -1, 0, -1, 1'b1);
        idle(20);

        // randomized traffic on all three configurations
        for (int n = 0; n < 8; n++) begin
            send(0, 9'($urandom_range(0, 255)), 1'b0, 2'b00, -1, 0, -1, 1'b1);
            idle($urandom_range(0, 20));
        end
        for (int n = 0; n < 6; n++) begin
            send(1, 9'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 1)), -1, 0, -1, 1'b1);
            idle(16 + $urandom_range(0, 8));
        end
        for (int n = 0; n < 6; n++) begin
            send(2, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), -1, 0, -1, 1'b1);
            idle(16 + $urandom_range(0, 8));
        end
        idle(40);

        chk("u0 words pending", q0.size(), 32'd0);
        chk("u1 words pending", q1.size(), 32'd0);
        chk("u2 words pending", q2.size(), 32'd0);
        chk("u0 overrun total", nov0, 32'd1);
        chk("u1 overrun total", nov1, 32'd0);
        chk("u2 overrun total", nov2, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
